banked_mem_resp: RTL and testbench

Synthesizable responder for the four-bank main-memory protocol that the cache controller drives. It accepts single-word read/write requests on the `addr`/`data_in`/`rd`/`wr` interface and interleaves them across four word-interleaved banks. Reads return data two cycles after acceptance; each bank stays occupied for four cycles. It sits below the cache in the memory hierarchy and replaces the behavioural main-memory model for synthesis and standalone verification.

---
 rtl/banked_mem_pkg.sv | 36 +++
 rtl/mem_bank.sv | 47 ++++
 rtl/banked_mem_resp.sv | 106 ++++++++++
 tb/tb_banked_mem_resp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
// Shared constants, field positions and types for the four-bank main-memory responder.
// Optional request checking is enabled with the BANKED_MEM_ERR_EN macro.
package banked_mem_pkg;

  localparam int NUM_BANKS        = 4;
  localparam int BANK_BUSY_CYCLES = 4;
  localparam int RD_LATENCY       = 2;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int BANK_W   = 2;
  localparam int BANK_LSB = 1;
  localparam int ROW_LSB  = 3;
  localparam int CNT_W    = $clog2(BANK_BUSY_CYCLES);

  typedef logic [BANK_W-1:0] bank_t;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_READ    = 2'd1,
    REQ_WRITE   = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_kind_e;

  // One read-pipeline stage; the first stage carries the row in the data field.
  typedef struct packed {
    logic              valid;
    bank_t             bank;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  function automatic bank_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_LSB +: BANK_W];
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One word-wide memory bank with its occupancy counter.
// Storage is not reset; only the busy counter is.
module mem_bank
  import banked_mem_pkg::*;
#(
  parameter int ROW_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              we,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] mem [2**ROW_W];
  logic [CNT_W-1:0]  cnt;

  // Occupancy counter: loads only from zero and saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (acc && (cnt == '0)) begin
      cnt <= CNT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (we && (cnt == '0)) begin
      mem[wr_row] <= wdata;
    end
  end

  assign busy  = (cnt != '0);
  assign rdata = mem[rd_row];

endmodule

// File: rtl/banked_mem_resp.sv
// Four-bank word-interleaved memory responder: decode, accept/stall, 2-cycle read pipeline.
// Define BANKED_MEM_ERR_EN to flag and block rd&wr collisions and odd addresses via err.
module banked_mem_resp
  import banked_mem_pkg::*;
#(
  parameter int ROW_W = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  req_kind_e         kind;
  bank_t             req_bank;
  logic [ROW_W-1:0]  req_row;
  logic              req_valid;
  logic              accept;
  logic [ROW_W-1:0]  rd_row;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  rd_stage_t         pipe [RD_LATENCY];
  logic              unused_bits;

  assign req_bank = bank_of(addr);
  assign req_row  = addr[ROW_LSB +: ROW_W];

  always_comb begin
    kind = REQ_NONE;
`ifdef BANKED_MEM_ERR_EN
    if ((rd & wr) | ((rd | wr) & addr[0])) begin
      kind = REQ_ILLEGAL;
    end else if (wr) begin
      kind = REQ_WRITE;
    end else if (rd) begin
      kind = REQ_READ;
    end else begin
      kind = REQ_NONE;
    end
`else
    // A simultaneous rd/wr resolves to a write; addr[0] plays no part.
    if (wr) begin
      kind = REQ_WRITE;
    end else if (rd) begin
      kind = REQ_READ;
    end else begin
      kind = REQ_NONE;
    end
`endif
  end

  assign req_valid = (kind == REQ_READ) || (kind == REQ_WRITE);
  assign stall     = req_valid &  busy[req_bank];
  assign accept    = req_valid & ~busy[req_bank];

`ifdef BANKED_MEM_ERR_EN
  assign err = (kind == REQ_ILLEGAL);
`else
  assign err = 1'b0;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic sel;
    assign sel = accept && (req_bank == bank_t'(g));

    mem_bank #(.ROW_W(ROW_W)) u_bank (
      .clk    (clk),
      .rst    (rst),
      .acc    (sel),
      .we     (sel && (kind == REQ_WRITE)),
      .wr_row (req_row),
      .wdata  (data_in),
      .rd_row (rd_row),
      .rdata  (bank_rdata[g]),
      .busy   (busy[g])
    );
  end

  // Stage 0 indexes the bank in the following cycle; stage 1 is the registered output.
  assign rd_row = pipe[0].data[ROW_W-1:0];

  // Read pipeline; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
    end else begin
      pipe[0].valid <= accept && (kind == REQ_READ);
      pipe[0].bank  <= req_bank;
      pipe[0].data  <= DATA_W'(req_row);
      pipe[1].valid <= pipe[0].valid;
      pipe[1].bank  <= pipe[0].bank;
      pipe[1].data  <= pipe[0].valid ? bank_rdata[pipe[0].bank] : '0;
    end
  end

  assign data_out = pipe[RD_LATENCY-1].data;

  assign unused_bits = ^{addr[0], pipe[0].data[DATA_W-1:ROW_W], pipe[1].valid, pipe[1].bank};

endmodule

// File: tb/tb_banked_mem_resp.sv
// Self-checking bench for banked_mem_resp: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model (last-accept time per bank).
module tb_banked_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_mem_resp #(.ROW_W(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .rd       (rd),
    .wr       (wr),
    .data_out (data_out),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  int          last_acc [4];
  logic [15:0] mem_m     [int];
  logic [15:0] ret_val   [int];
  bit          ret_known [int];

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        exp_stall;
    logic [3:0]  exp_busy;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) last_acc[i] = -100;
    ret_val.delete();
    ret_known.delete();
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic [3:0] exp_busy;
    logic       pres, ill, exp_stall, acc;
    int         b, key;
    @(negedge clk);
    rst = 1'b0; rd = r; wr = w; addr = a; data_in = d;
    cyc++;
    #1;
    for (int i = 0; i < 4; i++)
      exp_busy[i] = ((cyc - last_acc[i]) >= 1) && ((cyc - last_acc[i]) <= 3);
    pres = r | w;
`ifdef BANKED_MEM_ERR_EN
    ill = (r & w) | (pres & a[0]);
`else
    ill = 1'b0;
`endif
    b         = int'(a[2:1]);
    key       = int'(a[15:1]);
    exp_stall = pres && !ill && exp_busy[b];
    acc       = pres && !ill && !exp_busy[b];
    chk("model_stall", {15'h0, stall}, {15'h0, exp_stall});
    chk("model_err",   {15'h0, err},   {15'h0, ill});
    chk("model_busy",  {12'h0, busy},  {12'h0, exp_busy});
    if (ret_val.exists(cyc)) begin
      if (ret_known[cyc]) chk("model_data", data_out, ret_val[cyc]);
    end else begin
      chk("model_data_idle", data_out, 16'h0000);
    end
    if (acc) begin
      last_acc[b] = cyc;
      if (w) begin
        mem_m[key] = d;
      end else begin
        ret_known[cyc+2] = mem_m.exists(key);
        ret_val[cyc+2]   = mem_m.exists(key) ? mem_m[key] : 16'h0000;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Assert reset asynchronously for one cycle; counters must clear at once.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    cyc++;
    #1;
    chk("rst_busy_async", {12'h0, busy}, 16'h0000);
    chk("rst_data", data_out, 16'h0000);
    model_reset();
  endtask

  initial begin
    logic [15:0] ra;
    int          k;

    // Four writes to banks 0..3 then four reads; bank 0 is already free again by
    // the fifth cycle, so all four banks are never busy together.
    tbl[0]  = '{1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 4'b0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h0022, 16'h2222, 1'b0, 4'b0001, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h0024, 16'h3333, 1'b0, 4'b0011, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 16'h0026, 16'h4444, 1'b0, 4'b0111, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 4'b1110, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 4'b1101, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h0024, 16'h0000, 1'b0, 4'b1011, 16'h1111};
    tbl[7]  = '{1'b1, 1'b0, 16'h0026, 16'h0000, 1'b0, 4'b0111, 16'h2222};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b1110, 16'h3333};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b1100, 16'h4444};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b1000, 16'h0000};

    model_reset();
    repeat (2) @(negedge clk);

    // Idle after reset
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("reset_data",  data_out, 16'h0000);
    chk("reset_busy",  {12'h0, busy}, 16'h0000);
    chk("reset_stall", {15'h0, stall}, 16'h0000);
    chk("reset_err",   {15'h0, err}, 16'h0000);

    // Write then read back with fixed latency and busy window
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("beef_wr_stall", {15'h0, stall}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("beef_busy0", {15'h0, busy[0]}, 16'h0001);
    end
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("beef_rd_accept", {15'h0, stall}, 16'h0000);
    chk("beef_rd_busy0",  {15'h0, busy[0]}, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("beef_t1", data_out, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("beef_t2", data_out, 16'hBEEF);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("beef_t3", data_out, 16'h0000);
    idle(2);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      chk("tbl_stall", {15'h0, stall}, {15'h0, tbl[i].exp_stall});
      chk("tbl_busy",  {12'h0, busy},  {12'h0, tbl[i].exp_busy});
      chk("tbl_data",  data_out, tbl[i].exp_dout);
    end
    idle(3);

    // Same-bank read held through the busy window
    step(1'b0, 1'b1, 16'h0008, 16'h0808);
    idle(3);
    step(1'b0, 1'b1, 16'h0040, 16'h4040);
    idle(3);
    step(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("sb_first_accept", {15'h0, stall}, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 16'h0040, 16'h0000);
      chk("sb_stall", {15'h0, stall}, 16'h0001);
      if (i == 2) chk("sb_first_data", data_out, 16'h0808);
    end
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    chk("sb_late_accept", {15'h0, stall}, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("sb_second_data", data_out, 16'h4040);
    idle(3);

`ifdef BANKED_MEM_ERR_EN
    step(1'b1, 1'b1, 16'h0030, 16'h5A5A);
    chk("err_rdwr", {15'h0, err}, 16'h0001);
    chk("err_rdwr_stall", {15'h0, stall}, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("err_rdwr_nobusy", {12'h0, busy}, 16'h0000);
    step(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("err_odd", {15'h0, err}, 16'h0001);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("err_odd_nobusy", {12'h0, busy}, 16'h0000);
    chk("err_odd_idle", {15'h0, err}, 16'h0000);
`else
    step(1'b1, 1'b1, 16'h0030, 16'h5A5A);
    chk("noerr_rdwr", {15'h0, err}, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("noerr_rdwr_busy", {12'h0, busy}, 16'h0001);
    idle(2);
    step(1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("noerr_rdwr_is_write", data_out, 16'h5A5A);
    step(1'b0, 1'b1, 16'h0003, 16'h0303);
    chk("noerr_odd", {15'h0, err}, 16'h0000);
    idle(3);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("noerr_odd_alias", data_out, 16'h0303);
`endif
    idle(3);

    // Reset with a read in flight
    step(1'b1, 1'b0, 16'h0012, 16'h0000);
    chk("rst_rd_accept", {15'h0, stall}, 16'h0000);
    do_reset();
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rst_no_pulse_t2", data_out, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rst_no_pulse_t3", data_out, 16'h0000);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rst_mem_kept", data_out, 16'hBEEF);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ra = 16'($urandom_range(0, 31)) << 1;
      if ($urandom_range(0, 7) == 0) ra[0] = 1'b1;
      if ($urandom_range(0, 1) == 1) ra[15] = 1'b1;
      k = int'($urandom_range(0, 9));
      if (k < 4)       step(1'b1, 1'b0, ra, 16'h0000);
      else if (k < 8)  step(1'b0, 1'b1, ra, 16'($urandom));
      else if (k == 8) step(1'b1, 1'b1, ra, 16'($urandom));
      else             step(1'b0, 1'b0, ra, 16'h0000);
    end
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
